// File: rtl/vga_fb_reader_if.sv
// Frame-buffer read port between the VGA reader and the QQVGA buffer.
// The reader drives the address and receives synchronous RAM data.
interface vga_fb_reader_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;

  modport master (
    output mem_px_addr,
    input  mem_px_data
  );

  modport slave (
    input  mem_px_addr,
    output mem_px_data
  );
endinterface

// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA scan-out of a 160x120 RGB111 frame buffer, 4x replicated.
// Counter -> address -> RAM data -> registered colour, syncs delayed alike.
module vga_fb_reader #(
  parameter int AW = 15,
  parameter int DW = 3
) (
  input  logic              CLK,
  input  logic              rst,
  vga_fb_reader_if.master   fb,
  input  logic              pattern_en,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC,
  output logic              frame_start
);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       pat;
    logic [2:0] idx;
  } pix_t;

  localparam pix_t PIX_IDLE = '{
    act: 1'b0, hs: 1'b1, vs: 1'b1,
    fs: 1'b0, pat: 1'b0, idx: 3'd0
  };

  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  pix_t          s1_q, s1_d;
  pix_t          s2_q, s2_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    g_q, g_d;
  logic [3:0]    b_q, b_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;

  logic          act0;
  logic [AW-1:0] x_w;
  logic [AW-1:0] y_w;
  logic [2:0]    px;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == 10'd799) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == 10'd524) ? 10'd0
                                     : v_cnt_q + 10'd1;
    end
  end

  // y*160 built from shifts; 119*160+159 fits in 15 bits
  always_comb begin
    act0   = (h_cnt_q < 10'd640) && (v_cnt_q < 10'd480);
    x_w    = AW'(h_cnt_q[9:2]);
    y_w    = AW'(v_cnt_q[8:2]);
    addr_d = '0;
    if (act0) begin
      addr_d = (y_w << 7) + (y_w << 5) + x_w;
    end
  end

  always_comb begin
    s1_d     = PIX_IDLE;
    s1_d.act = act0;
    s1_d.hs  = !((h_cnt_q >= 10'd656) &&
                 (h_cnt_q < 10'd752));
    s1_d.vs  = !((v_cnt_q >= 10'd490) &&
                 (v_cnt_q < 10'd492));
    s1_d.fs  = (h_cnt_q == 10'd0) &&
               (v_cnt_q == 10'd0);
    s1_d.pat = pattern_en;
    s1_d.idx = h_cnt_q[9:7];
    s2_d     = s1_q;
  end

  always_comb begin
    px   = s2_q.pat ? s2_q.idx : fb.mem_px_data[2:0];
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (s2_q.act) begin
      r_d = {4{px[2]}};
      g_d = {4{px[1]}};
      b_d = {4{px[0]}};
    end
    hs_d = s2_q.hs;
    vs_d = s2_q.vs;
    fs_d = s2_q.fs;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      s1_q    <= PIX_IDLE;
      s2_q    <= PIX_IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign fb.mem_px_addr = addr_q;
  assign VGA_R          = r_q;
  assign VGA_G          = g_q;
  assign VGA_B          = b_q;
  assign VGA_HSYNC      = hs_q;
  assign VGA_VSYNC      = vs_q;
  assign frame_start    = fs_q;

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Display-side reader of the QQVGA frame buffer filled by the camera capture path. Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and reads the 160x120 buffer with 4x pixel replication in both axes. It issues one read address per pixel clock and expands each 3-bit RGB111 word into 4-bit-per-channel VGA outputs. It sits between the frame-buffer read port and the board's VGA connector.

## Interface
- AW, 15, frame-buffer address width.
- DW, 3, pixel width: bit 2 = R, bit 1 = G, bit 0 = B.
- CLK  in  1  25 MHz pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_px_data  in  DW  frame-buffer read data; synchronous RAM, valid one cycle after the address is sampled.
- pattern_en  in  1  1 = output colour bars instead of memory data; sampled each cycle.
- mem_px_addr  out  AW  frame-buffer read address, registered.
- VGA_R, VGA_G, VGA_B  out  4 each  colour outputs, registered.
- VGA_HSYNC, VGA_VSYNC  out  1 each  active-low syncs, registered.
- frame_start  out  1  one-cycle pulse aligned with the first active output pixel of each frame.

## Operation
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524; it increments when h_cnt wraps, and wraps to 0 after 524.
- Horizontal timing (h_cnt):
  - active 0..639
  - front porch 640..655
  - sync 656..751 (HSYNC low)
  - back porch 752..799
- Vertical timing (v_cnt):
  - active 0..479
  - front porch 480..489
  - sync 490..491 (VSYNC low)
  - back porch 492..524
- active = (h_cnt<640)&(v_cnt<480).
- Address generation:
  - x = h_cnt[9:2] (0..159), y = v_cnt[8:2] (0..119).
  - addr = y*160 + x, computed as (y<<7)+(y<<5)+x; maximum 19199, never exceeds AW bits.
  - During blanking, mem_px_addr = 0.
- Colour expansion: each channel is {4{bit}}, i.e. 4'hF or 4'h0.
  - When active is low at the output stage, all channels are 0 regardless of data or pattern.
- Pattern mode (pattern_en=1):
  - Colour index = h_cnt[9:7] of the delayed pixel (8 bars of 128 px, index 0..4, 5 bars visible), mapped as RGB = index bits {2,1,0}.
  - Memory data is ignored; addresses are still issued.
- frame_start is asserted for the output cycle where the delayed (h_cnt,v_cnt) = (0,0).

## Timing
- Three-stage pipeline from counter value (cycle t):
  - t+1: mem_px_addr valid.
  - t+2: mem_px_data valid.
  - t+3: VGA_R/G/B registered.
- Sync, active and pattern-index signals go through an equal 3-stage delay, so HSYNC/VSYNC/RGB/frame_start all refer to the same pixel.
- Reset values (asserted immediately, asynchronously):
  - h_cnt=0, v_cnt=0, mem_px_addr=0
  - VGA_R/G/B=0
  - VGA_HSYNC=1, VGA_VSYNC=1
  - frame_start=0
  - all delay stages cleared to blank/inactive-sync
- After reset release: the first rising edge samples counter (0,0); its pixel appears on the outputs 3 cycles later together with frame_start=1.
- Reset mid-frame restarts at (0,0) with the pipeline flushed; no partial sync pulse may appear after release.
- Wrap of h_cnt and v_cnt on the same edge (799,524→0,0) is legal and produces frame_start 3 cycles later.
- pattern_en changes take effect on the pixel whose counter is sampled in the same cycle; they are never glitch-merged within one pixel.
- Period checks: line = 800 cycles, frame = 420000 cycles, HSYNC low 96 cycles, VSYNC low 2 lines (1600 cycles).

## Test plan
- Reset: hold rst=0 for 5 cycles, then release → outputs are at their reset values during reset; frame_start=1 exactly at cycle 3 after release; RGB at that cycle reflects the data for address 0.
- Address map: RAM model returns addr[2:0] → mem_px_addr is 0 at (0,0), 1 at h=4, 159 at h=636/v=0, 160 at v=4/h=0, 19199 at (636,476); mem_px_addr=0 throughout blanking.
- Sync timing: run 2 full frames → HSYNC falls 656+3 cycles after each line start and is low 96 cycles; VSYNC low 1600 cycles starting at line 490; frame period 420000 cycles.
- Colour expansion and blanking: RAM returns 3'b101 everywhere → active pixels R=F, G=0, B=F; blanking pixels are all 0.
- Pattern mode: pattern_en=1 → pixels 0..127 black, 128..255 blue (001), 256..383 green (010), 512..639 red-ish per index 4 (100); RAM data is ignored.
- Reset mid-frame: assert rst at (300,200) → syncs go high immediately; after release, timing restarts cleanly at (0,0) with frame_start after 3 cycles.
